iter_div: RTL and testbench

ITER_DIV -- requirements
Module: iter_div

---
 rtl/iter_div.sv | 152 +++++++++++++++
 tb/tb_iter_div.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/iter_div.sv
// Iterative restoring divider with optional signed operands.
// Each operation takes W CALC cycles and one FIX cycle.
module iter_div #(
    parameter int W         = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sgn,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         div0,
    output logic         ovf
);

    // state | meaning
    // IDLE  | waiting for start, results held
    // CALC  | one quotient bit per cycle, W cycles
    // FIX   | apply signs and exceptions, publish results
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [W:0]    rem;
    logic [W-1:0]  dvd;
    logic [W-1:0]  mag_b;
    logic          sign_a;
    logic          sign_b;
    logic          zero_b;
    logic          ovf_op;

    logic          sgn_eff;
    logic          a_neg;
    logic          b_neg;
    logic [W-1:0]  mag_a_in;
    logic [W-1:0]  mag_b_in;
    logic          ovf_in;
    logic [W+1:0]  t;
    logic [W:0]    diff;
    logic          ge;
    logic [W-1:0]  q_fix;
    logic [W-1:0]  r_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == CW'(0)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Magnitude of the most negative value wraps to 2^(W-1), which is
    // exactly the unsigned value we want, so no extra bit is needed.
    always_comb begin
        sgn_eff  = SIGNED_EN && sgn;
        a_neg    = sgn_eff & a[W-1];
        b_neg    = sgn_eff & b[W-1];
        mag_a_in = a_neg ? (~a + 1'b1) : a;
        mag_b_in = b_neg ? (~b + 1'b1) : b;
        ovf_in   = sgn_eff && (a == {1'b1, {(W-1){1'b0}}}) && (b == {W{1'b1}});
    end

    always_comb begin
        t    = {rem, dvd[W-1]};
        ge   = (t >= {2'b00, mag_b});
        diff = t[W:0] - {1'b0, mag_b};
        q_fix = (sign_a ^ sign_b) ? (~dvd + 1'b1) : dvd;
        if (zero_b) begin
            q_fix = {W{1'b1}};
        end
        // Negating |a| restores the raw a pattern in the divide-by-zero case.
        r_fix = sign_a ? (~rem[W-1:0] + 1'b1) : rem[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            rem    <= '0;
            dvd    <= '0;
            mag_b  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            zero_b <= 1'b0;
            ovf_op <= 1'b0;
            done   <= 1'b0;
            q      <= '0;
            r      <= '0;
            div0   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem    <= '0;
                        dvd    <= mag_a_in;
                        mag_b  <= mag_b_in;
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        zero_b <= (b == '0);
                        ovf_op <= ovf_in;
                        cnt    <= CW'(W - 1);
                        div0   <= 1'b0;
                        ovf    <= 1'b0;
                    end
                end
                CALC: begin
                    rem <= ge ? diff : t[W:0];
                    dvd <= {dvd[W-2:0], ge};
                    if (cnt != CW'(0)) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    q    <= q_fix;
                    r    <= r_fix;
                    div0 <= zero_b;
                    ovf  <= ovf_op;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div (W=8, signed enabled) with hand-computed results.
module tb_iter_div;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sgn;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] q;
    logic [7:0] r;
    logic       div0;
    logic       ovf;

    int n_checks = 0;
    int n_errors = 0;

    iter_div #(.W(8), .SIGNED_EN(1'b1)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .div0  (div0),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic do_op(input string tag, input logic s, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] eq, input logic [7:0] er, input logic ed0, input logic eov);
        int lat;
        int busy_cnt;
        sgn = s; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'h00; b = 8'h00;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, 9);
        check({tag, " busy_cycles"}, busy_cnt, 9);
        check({tag, " q"}, q, eq);
        check({tag, " r"}, r, er);
        check({tag, " div0"}, div0, ed0);
        check({tag, " ovf"}, ovf, eov);
        check({tag, " busy_at_done"}, busy, 0);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, done, 0);
    endtask

    initial begin
        int dn_cnt;
        int first_k;
        int second_k;
        logic [7:0] q1, r1, q2, r2;

        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = 8'h00; b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst q", q, 0);
        check("rst r", r, 0);
        check("rst flags", {div0, ovf}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("u144_33",  1'b0, 8'd144, 8'd33,  8'd4,   8'd12,  1'b0, 1'b0);
        do_op("u100_100", 1'b0, 8'd100, 8'd100, 8'd1,   8'd0,   1'b0, 1'b0);
        do_op("u200_201", 1'b0, 8'd200, 8'd201, 8'd0,   8'd200, 1'b0, 1'b0);
        do_op("u255_129", 1'b0, 8'd255, 8'd129, 8'd1,   8'd126, 1'b0, 1'b0);
        do_op("s-7_2",    1'b1, 8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0, 1'b0);
        do_op("s7_-2",    1'b1, 8'h07,  8'hFE,  8'hFD,  8'h01,  1'b0, 1'b0);
        do_op("u5_0",     1'b0, 8'h05,  8'h00,  8'hFF,  8'h05,  1'b1, 1'b0);
        do_op("s-7_0",    1'b1, 8'hF9,  8'h00,  8'hFF,  8'hF9,  1'b1, 1'b0);
        do_op("s_ovf",    1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 1'b1);
        do_op("u80_ff",   1'b0, 8'h80,  8'hFF,  8'h00,  8'h80,  1'b0, 1'b0);
        do_op("s-100_7",  1'b1, 8'h9C,  8'h07,  8'hF2,  8'hFE,  1'b0, 1'b0);

        // Flags are cleared by the next accepted start.
        sgn = 1'b0; a = 8'd9; b = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("div0 set", div0, 1);
        sgn = 1'b0; a = 8'd9; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("div0 cleared", div0, 0);
        repeat (9) @(posedge clk);
        #1;
        check("after clear q", q, 3);
        @(posedge clk); #1;

        // Second start while busy is ignored.
        sgn = 1'b0; a = 8'd144; b = 8'd33; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dn_cnt = 0; first_k = -1; q1 = 8'h00; r1 = 8'h00;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                dn_cnt++;
                if (dn_cnt == 1) begin
                    first_k = k; q1 = q; r1 = r;
                end
            end
            start = (k == 2);
            if (k == 2) begin a = 8'd9; b = 8'd3; end
            @(posedge clk); #1;
        end
        check("hs done_count", dn_cnt, 1);
        check("hs latency", first_k, 9);
        check("hs q", q1, 4);
        check("hs r", r1, 12);

        // Start held during FIX is ignored, then taken in the next idle cycle.
        sgn = 1'b0; a = 8'd100; b = 8'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dn_cnt = 0; first_k = -1; second_k = -1;
        q1 = 8'h00; r1 = 8'h00; q2 = 8'h00; r2 = 8'h00;
        for (int k = 0; k < 26; k++) begin
            if (done) begin
                dn_cnt++;
                if (dn_cnt == 1) begin first_k = k; q1 = q; r1 = r; end
                if (dn_cnt == 2) begin second_k = k; q2 = q; r2 = r; end
            end
            if (k == 8) begin start = 1'b1; a = 8'd50; b = 8'd7; end
            if (k == 10) start = 1'b0;
            @(posedge clk); #1;
        end
        check("fix done_count", dn_cnt, 2);
        check("fix first_latency", first_k, 9);
        check("fix first_q", q1, 1);
        check("fix first_r", r1, 0);
        check("fix second_latency", second_k, 19);
        check("fix second_q", q2, 7);
        check("fix second_r", r2, 1);

        // Reset mid-CALC aborts the operation.
        sgn = 1'b0; a = 8'd200; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort q", q, 0);
        check("abort r", r, 0);
        check("abort flags", {div0, ovf}, 0);
        rst = 1'b0; start = 1'b0;
        dn_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) dn_cnt++;
            @(posedge clk); #1;
        end
        check("abort no_done", dn_cnt, 0);
        do_op("post_rst", 1'b0, 8'd144, 8'd33, 8'd4, 8'd12, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
